// File: rtl/pixel_write_coalescer_if.sv
// ============================================================================
// Module   : pixel_write_coalescer_if
// Purpose  : Pixel-stream input and Avalon-MM write bus of the coalescer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pixel_write_coalescer_if #(
  parameter int BUS_WIDTH   = 32,
  parameter int PIXEL_WIDTH = 16,
  parameter int ADDR_WIDTH  = 19
);
  localparam int c_LANE_BITS  = $clog2(BUS_WIDTH / PIXEL_WIDTH);
  localparam int c_WORD_WIDTH = ADDR_WIDTH - c_LANE_BITS;

  logic                      pixel_valid;
  logic [ADDR_WIDTH-1:0]     pixel_addr;
  logic [PIXEL_WIDTH-1:0]    pixel_color;
  logic                      pixel_ready;
  logic                      avm_write;
  logic [c_WORD_WIDTH-1:0]   avm_address;
  logic [BUS_WIDTH-1:0]      avm_writedata;
  logic [BUS_WIDTH/8-1:0]    avm_byteenable;
  logic                      avm_waitrequest;

  // The coalescer is the Avalon master and the pixel-stream consumer.
  modport master (
    input  pixel_valid, pixel_addr, pixel_color, avm_waitrequest,
    output pixel_ready, avm_write, avm_address, avm_writedata, avm_byteenable
  );

  modport slave (
    output pixel_valid, pixel_addr, pixel_color, avm_waitrequest,
    input  pixel_ready, avm_write, avm_address, avm_writedata, avm_byteenable
  );
endinterface

`default_nettype wire

// File: rtl/pixel_write_coalescer.sv
// ============================================================================
// Module   : pixel_write_coalescer
// Purpose  : Merges same-word pixel writes into one Avalon-MM word write.
//            Optional idle-flush timer enabled by COALESCE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pixel_write_coalescer #(
  parameter int BUS_WIDTH      = 32,
  parameter int PIXEL_WIDTH    = 16,
  parameter int ADDR_WIDTH     = 19,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic              clk,
  input  wire logic              n_rst,
  input  wire logic              flush,
  output logic                   idle,
  pixel_write_coalescer_if.master bus
);

  localparam int c_PPW        = BUS_WIDTH / PIXEL_WIDTH;
  localparam int c_LANE_BITS  = $clog2(c_PPW);
  localparam int c_LANE_W     = (c_LANE_BITS > 0) ? c_LANE_BITS : 1;
  localparam int c_BPP        = PIXEL_WIDTH / 8;
  localparam int c_BE_WIDTH   = BUS_WIDTH / 8;
  localparam int c_WORD_WIDTH = ADDR_WIDTH - c_LANE_BITS;
  localparam logic [c_BE_WIDTH-1:0] c_FULL_MASK = '1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ACCUM = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [c_WORD_WIDTH-1:0] r_word;
  logic [BUS_WIDTH-1:0]    r_data;
  logic [c_BE_WIDTH-1:0]   r_mask;

  logic [c_WORD_WIDTH-1:0] w_word;
  logic [c_LANE_W-1:0]     w_lane;
  logic [c_BE_WIDTH-1:0]   w_lane_mask;
  logic [c_BE_WIDTH-1:0]   w_merged_mask;
  logic [BUS_WIDTH-1:0]    w_lane_bits;
  logic [BUS_WIDTH-1:0]    w_lane_data;
  logic                    w_same;
  logic                    w_ready;
  logic                    w_load;
  logic                    w_merge;
  logic                    w_done;
  logic                    w_timeout;

  assign w_word = bus.pixel_addr[ADDR_WIDTH-1:c_LANE_BITS];

  generate
    if (c_LANE_BITS > 0) begin : g_lane
      assign w_lane = bus.pixel_addr[c_LANE_W-1:0];
    end else begin : g_single_lane
      assign w_lane = '0;
    end
  endgenerate

  assign w_lane_mask   = c_BE_WIDTH'({c_BPP{1'b1}}) << (w_lane * c_BPP);
  assign w_lane_bits   = BUS_WIDTH'({PIXEL_WIDTH{1'b1}}) << (w_lane * PIXEL_WIDTH);
  assign w_lane_data   = BUS_WIDTH'(bus.pixel_color) << (w_lane * PIXEL_WIDTH);
  assign w_merged_mask = r_mask | w_lane_mask;
  assign w_same        = (w_word == r_word);

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_load  = 1'b0;
    w_merge = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_EMPTY: begin
        w_ready = 1'b1;
        if (bus.pixel_valid) begin
          w_load = 1'b1;
          w_next = (c_PPW == 1) ? S_WRITE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        // A different-word pixel is refused and waits for the buffered word to drain.
        w_ready = w_same;
        if (bus.pixel_valid && w_same) begin
          w_merge = 1'b1;
          if ((w_merged_mask == c_FULL_MASK) || flush) begin
            w_next = S_WRITE;
          end
        end else if (bus.pixel_valid || flush || w_timeout) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!bus.avm_waitrequest) begin
          w_done = 1'b1;
          w_next = S_EMPTY;
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_EMPTY;
      r_word  <= '0;
      r_data  <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_word <= w_word;
        r_data <= w_lane_data;
        r_mask <= w_lane_mask;
      end else if (w_merge) begin
        r_data <= (r_data & ~w_lane_bits) | w_lane_data;
        r_mask <= w_merged_mask;
      end else if (w_done) begin
        r_mask <= '0;
      end
    end
  end

`ifdef COALESCE_TIMEOUT_EN
  localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [c_CNT_W-1:0] r_cnt;

  // Counts idle ACCUM cycles; restarts on every accepted pixel or state exit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if ((r_state != S_ACCUM) || w_merge || (w_next != S_ACCUM)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_ACCUM) && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign bus.pixel_ready    = w_ready;
  assign bus.avm_write      = (r_state == S_WRITE);
  assign bus.avm_address    = r_word;
  assign bus.avm_writedata  = r_data;
  assign bus.avm_byteenable = (r_state == S_WRITE) ? r_mask : '0;
  assign idle               = (r_state == S_EMPTY);

endmodule

`default_nettype wire

// File: tb/tb_pixel_write_coalescer.sv
// ============================================================================
// Module   : tb_pixel_write_coalescer
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            against a transaction-level word-merging model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pixel_write_coalescer;

  logic clk;
  logic n_rst;
  logic flush;
  logic idle;
  logic flush8;
  logic idle8;

  int compared;
  int mismatched;

  pixel_write_coalescer_if #(.BUS_WIDTH(32), .PIXEL_WIDTH(16), .ADDR_WIDTH(19)) bus ();
  pixel_write_coalescer_if #(.BUS_WIDTH(32), .PIXEL_WIDTH(8),  .ADDR_WIDTH(19)) bus8 ();

  pixel_write_coalescer #(
    .BUS_WIDTH(32), .PIXEL_WIDTH(16), .ADDR_WIDTH(19), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk(clk), .n_rst(n_rst), .flush(flush), .idle(idle), .bus(bus.master)
  );

  pixel_write_coalescer #(
    .BUS_WIDTH(32), .PIXEL_WIDTH(8), .ADDR_WIDTH(19), .TIMEOUT_CYCLES(16)
  ) u_dut8 (
    .clk(clk), .n_rst(n_rst), .flush(flush8), .idle(idle8), .bus(bus8.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #2;
    compared++;
    if (idle !== 1'b1 || bus.avm_write !== 1'b0 || bus.avm_byteenable !== 4'h0 ||
        bus.avm_address !== 18'h0 || bus.avm_writedata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_init: idle=%b write=%b be=%h addr=%h data=%h want 1 0 0 0 0",
               idle, bus.avm_write, bus.avm_byteenable, bus.avm_address, bus.avm_writedata);
    end
    cyc();
    n_rst = 1'b1;
    // Drive into WRITE and hold it there with waitrequest.
    bus.avm_waitrequest = 1'b1;
    cyc();
    bus.pixel_valid = 1'b1; bus.pixel_addr = 19'h10; bus.pixel_color = 16'hBEEF;
    cyc();
    bus.pixel_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    compared++;
    if (bus.avm_write !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_prewrite: avm_write=%b want 1", bus.avm_write);
    end
    #3;
    n_rst = 1'b0;
    #1;
    compared++;
    if (bus.avm_write !== 1'b0 || bus.avm_byteenable !== 4'h0 || idle !== 1'b1 ||
        bus.pixel_ready !== 1'b1 || bus.avm_writedata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_midwrite: write=%b be=%h idle=%b ready=%b data=%h want 0 0 1 1 0",
               bus.avm_write, bus.avm_byteenable, idle, bus.pixel_ready, bus.avm_writedata);
    end
    cyc();
    n_rst = 1'b1;
    bus.avm_waitrequest = 1'b0;
    begin
      bit saw;
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
        cyc();
        if (bus.avm_write) saw = 1'b1;
      end
      compared++;
      if (saw !== 1'b0 || idle !== 1'b1) begin
        mismatched++;
        $display("FAIL reset_no_write: saw_write=%b idle=%b want 0 1", saw, idle);
      end
    end
  endtask

  task automatic test_merge();
    bus.avm_waitrequest = 1'b0;
    bus.pixel_valid = 1'b1; bus.pixel_addr = 19'h00010; bus.pixel_color = 16'hF800;
    cyc();
    bus.pixel_addr = 19'h00011; bus.pixel_color = 16'h07E0;
    compared++;
    if (bus.pixel_ready !== 1'b1 || bus.avm_write !== 1'b0) begin
      mismatched++;
      $display("FAIL merge_second_ready: ready=%b write=%b want 1 0", bus.pixel_ready, bus.avm_write);
    end
    cyc();
    bus.pixel_valid = 1'b0;
    compared++;
    if (bus.avm_write !== 1'b1 || bus.avm_address !== 18'h00008 ||
        bus.avm_writedata !== 32'h07E0F800 || bus.avm_byteenable !== 4'hF) begin
      mismatched++;
      $display("FAIL merge_word: write=%b addr=%h data=%h be=%h want 1 00008 07e0f800 f",
               bus.avm_write, bus.avm_address, bus.avm_writedata, bus.avm_byteenable);
    end
    cyc();
    compared++;
    if (idle !== 1'b1 || bus.avm_write !== 1'b0 || bus.avm_byteenable !== 4'h0) begin
      mismatched++;
      $display("FAIL merge_done: idle=%b write=%b be=%h want 1 0 0", idle, bus.avm_write, bus.avm_byteenable);
    end
  endtask

  task automatic test_flush_partial();
    bus.pixel_valid = 1'b1; bus.pixel_addr = 19'h00021; bus.pixel_color = 16'h001F;
    cyc();
    bus.pixel_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    compared++;
    if (bus.avm_write !== 1'b1 || bus.avm_address !== 18'h00010 ||
        bus.avm_writedata !== 32'h001F0000 || bus.avm_byteenable !== 4'hC) begin
      mismatched++;
      $display("FAIL flush_word: write=%b addr=%h data=%h be=%h want 1 00010 001f0000 c",
               bus.avm_write, bus.avm_address, bus.avm_writedata, bus.avm_byteenable);
    end
    cyc();
    compared++;
    if (idle !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_idle: idle=%b want 1", idle);
    end
  endtask

  task automatic test_word_change_stall();
    bus.avm_waitrequest = 1'b1;
    bus.pixel_valid = 1'b1; bus.pixel_addr = 19'd4; bus.pixel_color = 16'hAAAA;
    cyc();
    bus.pixel_addr = 19'd9; bus.pixel_color = 16'h5555;
    #1;
    compared++;
    if (bus.pixel_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_diff_word_ready: ready=%b want 0", bus.pixel_ready);
    end
    cyc();
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (bus.pixel_ready !== 1'b0 || bus.avm_write !== 1'b1 || bus.avm_address !== 18'd2 ||
          bus.avm_writedata !== 32'h0000AAAA || bus.avm_byteenable !== 4'h3) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: ready=%b write=%b addr=%h data=%h be=%h want 0 1 2 0000aaaa 3",
                 i, bus.pixel_ready, bus.avm_write, bus.avm_address, bus.avm_writedata, bus.avm_byteenable);
      end
      if (i == 4) bus.avm_waitrequest = 1'b0;
      cyc();
    end
    compared++;
    if (bus.pixel_ready !== 1'b1 || idle !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_release: ready=%b idle=%b want 1 1", bus.pixel_ready, idle);
    end
    cyc();
    bus.pixel_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    compared++;
    if (bus.avm_write !== 1'b1 || bus.avm_address !== 18'd4 ||
        bus.avm_writedata !== 32'h55550000 || bus.avm_byteenable !== 4'hC) begin
      mismatched++;
      $display("FAIL stall_second_word: write=%b addr=%h data=%h be=%h want 1 4 55550000 c",
               bus.avm_write, bus.avm_address, bus.avm_writedata, bus.avm_byteenable);
    end
    cyc();
  endtask

  task automatic test_pixel8();
    for (int i = 0; i < 4; i++) begin
      bus8.pixel_valid = 1'b1;
      bus8.pixel_addr  = 19'(32'h40 + i);
      bus8.pixel_color = 8'((i + 1) * 8'h11);
      cyc();
    end
    bus8.pixel_valid = 1'b0;
    compared++;
    if (bus8.avm_write !== 1'b1 || bus8.avm_address !== 17'h10 ||
        bus8.avm_writedata !== 32'h44332211 || bus8.avm_byteenable !== 4'hF) begin
      mismatched++;
      $display("FAIL pix8_word: write=%b addr=%h data=%h be=%h want 1 10 44332211 f",
               bus8.avm_write, bus8.avm_address, bus8.avm_writedata, bus8.avm_byteenable);
    end
    cyc();
    compared++;
    if (idle8 !== 1'b1) begin
      mismatched++;
      $display("FAIL pix8_idle: idle=%b want 1", idle8);
    end
  endtask

  task automatic test_timeout();
    int first;
    bus.avm_waitrequest = 1'b0;
    bus.pixel_valid = 1'b1; bus.pixel_addr = 19'd6; bus.pixel_color = 16'h1234;
    cyc();
    bus.pixel_valid = 1'b0;
    first = 0;
`ifdef COALESCE_TIMEOUT_EN
    for (int k = 1; k <= 30 && first == 0; k++) begin
      cyc();
      if (bus.avm_write) first = k;
    end
    compared++;
    if (first !== 16 || bus.avm_address !== 18'd3 || bus.avm_byteenable !== 4'h3 ||
        bus.avm_writedata !== 32'h00001234) begin
      mismatched++;
      $display("FAIL timeout_write: cycle=%0d addr=%h be=%h data=%h want 16 3 3 00001234",
               first, bus.avm_address, bus.avm_byteenable, bus.avm_writedata);
    end
    cyc();
`else
    for (int k = 1; k <= 100; k++) begin
      cyc();
      if (bus.avm_write && first == 0) first = k;
    end
    compared++;
    if (first !== 0) begin
      mismatched++;
      $display("FAIL timeout_disabled: write at cycle %0d want none", first);
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
`endif
    compared++;
    if (idle !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_idle: idle=%b want 1", idle);
    end
  endtask

  // Model: a word closes when it fills, a different-word pixel arrives, or a flush
  // arrives while pixels are buffered.
  logic [17:0] ew_addr[$];
  logic [31:0] ew_data[$];
  logic [3:0]  ew_be[$];

  task automatic model_close(input logic [17:0] w, input logic [15:0] c0, input logic [15:0] c1,
                             input bit s0, input bit s1);
    ew_addr.push_back(w);
    ew_data.push_back({c1, c0});
    ew_be.push_back({s1, s1, s0, s0});
  endtask

  task automatic test_random();
    int          kind[$];
    logic [18:0] it_addr[$];
    logic [15:0] it_col[$];
    bit          cur_v;
    logic [17:0] cur_w;
    logic [15:0] col[2];
    bit          set[2];
    int          idx, gap, cycles, writes;
    bit          accepted;

    for (int i = 0; i < 240; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        kind.push_back(1); it_addr.push_back('0); it_col.push_back('0);
      end else begin
        kind.push_back(0);
        it_addr.push_back(19'($urandom_range(0, 11)));
        it_col.push_back(16'($urandom));
      end
    end
    kind.push_back(1); it_addr.push_back('0); it_col.push_back('0);

    cur_v = 0; cur_w = '0; col[0] = '0; col[1] = '0; set[0] = 0; set[1] = 0;
    for (int i = 0; i < kind.size(); i++) begin
      if (kind[i] == 0) begin
        if (cur_v && (it_addr[i] >> 1) != cur_w) begin
          model_close(cur_w, col[0], col[1], set[0], set[1]);
          cur_v = 0;
        end
        if (!cur_v) begin
          cur_v = 1; cur_w = 18'(it_addr[i] >> 1);
          col[0] = '0; col[1] = '0; set[0] = 0; set[1] = 0;
        end
        col[it_addr[i][0]] = it_col[i];
        set[it_addr[i][0]] = 1;
        if (set[0] && set[1]) begin
          model_close(cur_w, col[0], col[1], set[0], set[1]);
          cur_v = 0;
        end
      end else if (cur_v) begin
        model_close(cur_w, col[0], col[1], set[0], set[1]);
        cur_v = 0;
      end
    end

    idx = 0; gap = 0; cycles = 0; writes = 0;
    while ((idx < kind.size() || ew_addr.size() > 0 || !idle) && cycles < 5000) begin
      @(negedge clk);
      if (bus.avm_write && !bus.avm_waitrequest) begin
        compared++;
        writes++;
        if (ew_addr.size() == 0) begin
          mismatched++;
          $display("FAIL rand_unexpected_write: addr=%h data=%h be=%h want no write",
                   bus.avm_address, bus.avm_writedata, bus.avm_byteenable);
        end else begin
          if (bus.avm_address !== ew_addr[0] || bus.avm_writedata !== ew_data[0] ||
              bus.avm_byteenable !== ew_be[0]) begin
            mismatched++;
            $display("FAIL rand_write[%0d]: addr=%h data=%h be=%h want %h %h %h", writes,
                     bus.avm_address, bus.avm_writedata, bus.avm_byteenable,
                     ew_addr[0], ew_data[0], ew_be[0]);
          end
          void'(ew_addr.pop_front()); void'(ew_data.pop_front()); void'(ew_be.pop_front());
        end
      end
      accepted = bus.pixel_valid && bus.pixel_ready;
      cyc();
      cycles++;
      bus.avm_waitrequest = ($urandom_range(0, 2) == 0);
      flush = 1'b0;
      if (accepted) begin
        idx++;
        gap = $urandom_range(0, 2);
      end
      if (gap > 0) begin
        bus.pixel_valid = 1'b0;
        gap--;
      end else if (idx < kind.size()) begin
        if (kind[idx] == 0) begin
          bus.pixel_valid = 1'b1; bus.pixel_addr = it_addr[idx]; bus.pixel_color = it_col[idx];
        end else begin
          bus.pixel_valid = 1'b0; flush = 1'b1;
          idx++;
          gap = $urandom_range(0, 2);
        end
      end else begin
        bus.pixel_valid = 1'b0;
      end
    end
    bus.avm_waitrequest = 1'b0;
    compared++;
    if (cycles >= 5000 || ew_addr.size() != 0) begin
      mismatched++;
      $display("FAIL rand_drain: cycles=%0d pending_writes=%0d want <5000 and 0", cycles, ew_addr.size());
    end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    n_rst = 1'b0; flush = 1'b0; flush8 = 1'b0;
    bus.pixel_valid = 1'b0; bus.pixel_addr = '0; bus.pixel_color = '0; bus.avm_waitrequest = 1'b0;
    bus8.pixel_valid = 1'b0; bus8.pixel_addr = '0; bus8.pixel_color = '0; bus8.avm_waitrequest = 1'b0;
    test_reset();
    test_merge();
    test_flush_partial();
    test_word_change_stall();
    test_pixel8();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
